alu_seq: RTL and testbench
==========================

# alu_seq

Sequential, parametrised successor to the core ALU. It accepts one operation per valid/ready handshake and supports arithmetic, logic, shift, compare and conditional-jump operations, plus an optional iterative multiplier. Every result is registered and held until the consumer accepts it. It sits between the operand-fetch stage and the writeback/PC-update logic of `bb_core`.

## Interface
- `DW`, 16: operand and result width, 8..32.
- `SHW`, 4: shift-amount width, equal to clog2(DW). Only the low `SHW` bits of `i_perand1` are used for shifts.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_op_valid`  in  1  operation request.
- `o_op_ready`  out  1  block can accept an operation this cycle.
- `i_op_sel`  in  4  operation code (see Operation).
- `i_perand0`, `i_perand1`  in  DW  operands.
- `i_direct_addr`  in  DW  jump target.
- `i_program_addr`  in  DW  current PC.
- `o_result_valid`  out  1  `o_alu_output` is valid.
- `i_result_ready`  in  1  consumer accepts the result.
- `o_alu_output`  out  DW  registered result.
- `o_err`  out  1  held result came from an illegal opcode.

## Operation
- Opcodes:
  - 0 ADD: p0+p1, mod 2^DW.
  - 1 SUB: p0−p1, mod 2^DW.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SHL: p0<<p1[SHW-1:0].
  - 6 SHR: logical right shift, same amount rule.
  - 7 CMP: {DW-3 zeros, gt, lt, eq}, unsigned compare.
  - 8 JMPC: result is `i_direct_addr` if p0 != p1, else `i_program_addr`+1 (mod 2^DW).
  - 9 MUL: low DW bits of p0*p1, unsigned.
  - 10–15: illegal. Result is 0 and `o_err`=1.
- The handshake fires when `i_op_valid && o_op_ready`. Operands and opcode are captured on that edge. Inputs are don't-care otherwise.
- FSM states IDLE, MUL, DONE:
  - IDLE: `o_op_ready`=1. On fire, a single-cycle op → DONE with the result registered; MUL → MUL with the iteration counter at 0.
  - MUL: one shift-add step per cycle. A DW-bit accumulator, multiplicand and multiplier shift registers, and a counter of width SHW+1 are used. After DW steps → DONE with the accumulator loaded to `o_alu_output`. `o_op_ready`=0.
  - DONE: `o_result_valid`=1, and `o_alu_output`/`o_err` are held stable. `o_op_ready` = `i_result_ready`. If the result is accepted in the same cycle as a new fire, the new op is processed as from IDLE (back-to-back). If accepted with no new fire → IDLE. If not accepted → stay.
- `i_op_valid` may drop without a fire. The block takes no action.

## Timing
- Reset values: state=IDLE, `o_op_ready`=1, `o_result_valid`=0, `o_alu_output`=0, `o_err`=0, and all internal registers 0.
- Single-cycle ops: fire at edge N, `o_result_valid`=1 after edge N. Latency 1. Throughput 1/cycle when `i_result_ready` is held high.
- MUL: fire at edge N, `o_result_valid`=1 after edge N+DW. Latency DW+1.
- `o_result_valid` falls on the edge where `i_result_ready`=1 unless a new single-cycle op fires on that same edge. In that case valid stays 1 and the output updates.
- Reset asserted mid-MUL or in DONE aborts immediately (asynchronous). The result is lost and all outputs return to reset values. There is no partial-result leakage after deassertion.
- All outputs are register-driven, except `o_op_ready`, which in DONE is combinational from `i_result_ready`.

## Configuration
- `ALU_MUL_EN`:
  - Defined: the MUL state, counter and shift registers are compiled in, and opcode 9 behaves as above.
  - Undefined: no multiplier logic. Opcode 9 is illegal (result 0, `o_err`=1, latency 1), and the FSM has only IDLE/DONE.

## Test plan
- Reset, then ADD with p0=16'hFFFF, p1=16'h0002 and `i_result_ready`=1 → one cycle later `o_alu_output`=16'h0001, `o_result_valid`=1, `o_err`=0.
- CMP 5 vs 9, then CMP 9 vs 9, back-to-back with ready high → outputs 16'h0002 then 16'h0001 on consecutive cycles, `o_op_ready` high throughout.
- JMPC with p0=3, p1=4, direct=16'h0100, pc=16'h0020 → 16'h0100. Then p0=p1=4 with pc=16'hFFFF → 16'h0000.
- MUL 16'h0123 × 16'h0010 (`ALU_MUL_EN` defined, DW=16) → `o_op_ready`=0 for 16 cycles, then 16'h1230 valid at latency 17. Without the macro → 0 with `o_err`=1 at latency 1.
- SHL of 16'h0001 by `i_perand1`=16'h0013 → 16'h0008 (only the low 4 bits are used). Hold `i_result_ready`=0 for 5 cycles → output and valid stay stable and `o_op_ready` stays 0.
- Assert `rst_n`=0 at MUL cycle 7 → `o_result_valid`=0 and `o_alu_output`=0 immediately. After release, `o_op_ready`=1, and an ADD of 1+1 returns 2.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshakes on operation and result, registered outputs.
// Define ALU_MUL_EN to compile in the iterative shift-add multiplier for opcode 9.
module alu_seq #(
  parameter int DW  = 16,
  parameter int SHW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_op_valid,
  output logic          o_op_ready,
  input  logic [3:0]    i_op_sel,
  input  logic [DW-1:0] i_perand0,
  input  logic [DW-1:0] i_perand1,
  input  logic [DW-1:0] i_direct_addr,
  input  logic [DW-1:0] i_program_addr,
  output logic          o_result_valid,
  input  logic          i_result_ready,
  output logic [DW-1:0] o_alu_output,
  output logic          o_err
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_CMP  = 4'd7,
    OP_JMPC = 4'd8,
    OP_MUL  = 4'd9
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    ST_MUL  = 2'd1,
`endif
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          fire;
  logic          is_mul;
  logic [DW-1:0] single_res;
  logic          single_err;
  logic [DW-1:0] res_q;
  logic          err_q;
  logic          valid_q;

  assign fire = i_op_valid && o_op_ready;

`ifdef ALU_MUL_EN
  localparam int CNT_W = SHW + 1;

  logic [DW-1:0]    acc_q, mcand_q, mplr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    acc_step;
  logic             mul_last;

  assign is_mul   = (i_op_sel == OP_MUL);
  assign acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
  assign mul_last = (cnt_q == CNT_W'(DW - 1));
`else
  assign is_mul = 1'b0;
`endif

  // Single-cycle result from the live operands; only sampled on a fire.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    single_res = '0;
    single_err = 1'b0;
    case (i_op_sel)
      OP_ADD:  single_res = i_perand0 + i_perand1;
      OP_SUB:  single_res = i_perand0 - i_perand1;
      OP_AND:  single_res = i_perand0 & i_perand1;
      OP_OR:   single_res = i_perand0 | i_perand1;
      OP_XOR:  single_res = i_perand0 ^ i_perand1;
      OP_SHL:  single_res = i_perand0 << i_perand1[SHW-1:0];
      OP_SHR:  single_res = i_perand0 >> i_perand1[SHW-1:0];
      OP_CMP:  single_res = {{(DW-3){1'b0}}, (i_perand0 > i_perand1),
                             (i_perand0 < i_perand1), (i_perand0 == i_perand1)};
      OP_JMPC: single_res = (i_perand0 != i_perand1) ? i_direct_addr
                                                     : i_program_addr + DW'(1);
      default: single_err = 1'b1;
    endcase
  end

  // State register; valid is registered from the next state so it is flop-driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      valid_q <= (state_d == ST_DONE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fire) state_d = is_mul ? state_e'(2'd1) : ST_DONE;
      end
`ifdef ALU_MUL_EN
      ST_MUL: begin
        if (mul_last) state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (fire)                state_d = is_mul ? state_e'(2'd1) : ST_DONE;
        else if (i_result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // In DONE the block can take a new op exactly when the held result is being accepted.
  always_comb begin
    o_op_ready = 1'b0;
    case (state_q)
      ST_IDLE: o_op_ready = 1'b1;
      ST_DONE: o_op_ready = i_result_ready;
      default: o_op_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, so an aborted multiply leaves nothing behind.
      res_q   <= '0;
      err_q   <= 1'b0;
`ifdef ALU_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      if (fire && !is_mul) begin
        res_q <= single_res;
        err_q <= single_err;
      end
`ifdef ALU_MUL_EN
      if (fire && is_mul) begin
        acc_q   <= '0;
        mcand_q <= i_perand0;
        mplr_q  <= i_perand1;
        cnt_q   <= '0;
      end else if (state_q == ST_MUL) begin
        acc_q   <= acc_step;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + CNT_W'(1);
        if (mul_last) begin
          res_q <= acc_step;
          err_q <= 1'b0;
        end
      end
`endif
    end
  end

  assign o_result_valid = valid_q;
  assign o_alu_output   = res_q;
  assign o_err          = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops against a
// plain-arithmetic reference model. Honours ALU_MUL_EN the same way as the design.
module tb_alu_seq;
  localparam int DW  = 16;
  localparam int SHW = 4;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_op_valid = 1'b0;
  logic          o_op_ready;
  logic [3:0]    i_op_sel = '0;
  logic [DW-1:0] i_perand0 = '0, i_perand1 = '0, i_direct_addr = '0, i_program_addr = '0;
  logic          o_result_valid;
  logic          i_result_ready = 1'b0;
  logic [DW-1:0] o_alu_output;
  logic          o_err;

  int vectors = 0;
  int miscompares = 0;

  alu_seq #(.DW(DW), .SHW(SHW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_op_valid(i_op_valid), .o_op_ready(o_op_ready), .i_op_sel(i_op_sel),
    .i_perand0(i_perand0), .i_perand1(i_perand1),
    .i_direct_addr(i_direct_addr), .i_program_addr(i_program_addr),
    .o_result_valid(o_result_valid), .i_result_ready(i_result_ready),
    .o_alu_output(o_alu_output), .o_err(o_err)
  );

  always #5 clk = ~clk;

  // Reference model: returns {err, result}.
  function automatic logic [DW:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a, b, da, pa);
    logic [2*DW-1:0] prod;
    int amt;
    amt = int'(b) % DW;
    case (op)
      4'd0: return {1'b0, DW'(a + b)};
      4'd1: return {1'b0, DW'(a - b)};
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: return {1'b0, DW'(a << amt)};
      4'd6: return {1'b0, DW'(a >> amt)};
      4'd7: return {1'b0, DW'((a > b ? 4 : 0) + (a < b ? 2 : 0) + (a == b ? 1 : 0))};
      4'd8: return {1'b0, (a != b) ? da : DW'(pa + 1)};
      4'd9: begin
        if (!MUL_EN) return {1'b1, {DW{1'b0}}};
        prod = (2*DW)'(a) * (2*DW)'(b);
        return {1'b0, prod[DW-1:0]};
      end
      default: return {1'b1, {DW{1'b0}}};
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op);
    return (op == 4'd9 && MUL_EN) ? DW + 1 : 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fire one op; afterwards the operand inputs are scrambled to prove they were captured.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, b, da, pa);
    int guard = 0;
    while (!o_op_ready && guard < 4*DW) begin tick(); guard++; end
    vectors++;
    if (o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: o_op_ready=%b required 1", o_op_ready);
    end
    i_op_sel = op; i_perand0 = a; i_perand1 = b; i_direct_addr = da; i_program_addr = pa;
    i_op_valid = 1'b1;
    tick();
    i_op_valid = 1'b0;
    i_perand0 = DW'($urandom); i_perand1 = DW'($urandom);
    i_direct_addr = DW'($urandom); i_program_addr = DW'($urandom);
  endtask

  // Full transaction: fire, wait for result (bounded), check value/err/latency,
  // hold the result for `hold` cycles with ready low, then accept it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [DW-1:0] a, b, da, pa,
                        input int hold);
    logic [DW:0] exp;
    int lat, low_cnt, exp_lat;
    exp = ref_alu(op, a, b, da, pa);
    exp_lat = ref_latency(op);
    i_result_ready = 1'b0;
    issue(op, a, b, da, pa);
    lat = 1; low_cnt = 0;
    while (!o_result_valid && lat < DW + 8) begin
      if (!o_op_ready) low_cnt++;
      tick();
      lat++;
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d required %0d", tag, lat, exp_lat);
    end
    vectors++;
    if (low_cnt !== exp_lat - 1) begin
      miscompares++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", tag, low_cnt, exp_lat - 1);
    end
    vectors++;
    if (o_alu_output !== exp[DW-1:0] || o_err !== exp[DW]) begin
      miscompares++;
      $display("FAIL %s_result: out=%h err=%b required out=%h err=%b (op=%0d a=%h b=%h)",
               tag, o_alu_output, o_err, exp[DW-1:0], exp[DW], op, a, b);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      vectors++;
      if (o_result_valid !== 1'b1 || o_alu_output !== exp[DW-1:0] || o_err !== exp[DW] ||
          o_op_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s_hold%0d: valid=%b out=%h err=%b ready=%b required 1/%h/%b/0",
                 tag, i, o_result_valid, o_alu_output, o_err, o_op_ready, exp[DW-1:0], exp[DW]);
      end
    end
    i_result_ready = 1'b1;
    tick();
    i_result_ready = 1'b0;
    vectors++;
    if (o_result_valid !== 1'b0 || o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_accept: valid=%b ready=%b required 0/1", tag, o_result_valid, o_op_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (o_op_ready !== 1'b1 || o_result_valid !== 1'b0 || o_alu_output !== '0 || o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b valid=%b out=%h err=%b required 1/0/0000/0",
               o_op_ready, o_result_valid, o_alu_output, o_err);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    i_result_ready = 1'b1;
    issue(4'd0, 16'hFFFF, 16'h0002, '0, '0);
    vectors++;
    if (o_alu_output !== 16'h0001 || o_result_valid !== 1'b1 || o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL add_wrap: out=%h valid=%b err=%b required 0001/1/0",
               o_alu_output, o_result_valid, o_err);
    end
    tick();
    i_result_ready = 1'b0;
  endtask

  task automatic test_cmp_back_to_back();
    i_result_ready = 1'b1;
    i_op_sel = 4'd7; i_perand0 = 16'd5; i_perand1 = 16'd9; i_op_valid = 1'b1;
    tick();
    vectors++;
    if (o_alu_output !== 16'h0002 || o_result_valid !== 1'b1 || o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmp_lt: out=%h valid=%b ready=%b required 0002/1/1",
               o_alu_output, o_result_valid, o_op_ready);
    end
    i_perand0 = 16'd9;
    tick();
    i_op_valid = 1'b0;
    vectors++;
    if (o_alu_output !== 16'h0001 || o_result_valid !== 1'b1 || o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmp_eq: out=%h valid=%b ready=%b required 0001/1/1",
               o_alu_output, o_result_valid, o_op_ready);
    end
    tick();
    vectors++;
    if (o_result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL cmp_drain: valid=%b required 0", o_result_valid);
    end
    i_result_ready = 1'b0;
  endtask

  task automatic test_jmpc();
    run_op("jmpc_taken", 4'd8, 16'd3, 16'd4, 16'h0100, 16'h0020, 0);
    run_op("jmpc_wrap", 4'd8, 16'd4, 16'd4, 16'h0100, 16'hFFFF, 0);
  endtask

  task automatic test_mul();
    run_op("mul", 4'd9, 16'h0123, 16'h0010, '0, '0, 0);
    run_op("mul_max", 4'd9, 16'hFFFF, 16'hFFFF, '0, '0, 1);
  endtask

  task automatic test_shl_hold();
    run_op("shl_hold", 4'd5, 16'h0001, 16'h0013, '0, '0, 5);
    run_op("shr", 4'd6, 16'h8000, 16'h001F, '0, '0, 0);
    run_op("illegal", 4'd12, 16'h1234, 16'h5678, '0, '0, 2);
  endtask

  task automatic test_reset_mid_op();
    i_result_ready = 1'b0;
    issue(4'd9, 16'h0123, 16'h0010, '0, '0);
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_result_valid !== 1'b0 || o_alu_output !== '0 || o_err !== 1'b0 || o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_abort: valid=%b out=%h err=%b ready=%b required 0/0000/0/1",
               o_result_valid, o_alu_output, o_err, o_op_ready);
    end
    tick();
    rst_n = 1'b1;
    repeat (DW + 2) tick();
    vectors++;
    if (o_result_valid !== 1'b0 || o_alu_output !== '0 || o_op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_no_leak: valid=%b out=%h ready=%b required 0/0000/1",
               o_result_valid, o_alu_output, o_op_ready);
    end
    run_op("post_reset_add", 4'd0, 16'd1, 16'd1, '0, '0, 0);
  endtask

  task automatic test_back_to_back();
    logic [3:0]    op;
    logic [DW-1:0] a, b, da, pa;
    logic [DW:0]   exp;
    i_result_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd9 && MUL_EN);
      a = DW'($urandom); b = DW'($urandom); da = DW'($urandom); pa = DW'($urandom);
      if (i % 4 == 0) b = a;
      exp = ref_alu(op, a, b, da, pa);
      i_op_sel = op; i_perand0 = a; i_perand1 = b; i_direct_addr = da; i_program_addr = pa;
      i_op_valid = 1'b1;
      tick();
      vectors++;
      if (o_alu_output !== exp[DW-1:0] || o_err !== exp[DW] || o_result_valid !== 1'b1 ||
          o_op_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b%0d: out=%h err=%b valid=%b ready=%b required %h/%b/1/1 (op=%0d)",
                 i, o_alu_output, o_err, o_result_valid, o_op_ready, exp[DW-1:0], exp[DW], op);
      end
    end
    i_op_valid = 1'b0;
    tick();
    i_result_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      run_op("rand", op, DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
             int'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_cmp_back_to_back();
    test_jmpc();
    test_mul();
    test_shl_hold();
    test_back_to_back();
    test_random();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
